// File: rtl/onehot_seq_decoder.sv
// Registered one-hot decoder with an up/down stepping sequencer (wrap or saturate).
// Optional range checking of loaded indices is enabled by defining ONEHOT_RANGE_CHK_EN.
module onehot_seq_decoder #(
    parameter int OUT_W     = 8,
    parameter int SEL_W     = 3,
    parameter bit AUTO_WRAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [SEL_W-1:0] sel,
    input  logic             step,
    input  logic             dir,
    output logic [OUT_W-1:0] onehot,
    output logic [SEL_W-1:0] idx,
    output logic             valid,
    output logic             wrap,
    output logic             err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Index arithmetic is one bit wider so OUT_W = 2**SEL_W is still representable.
    localparam logic [SEL_W:0] OUT_W_X = (SEL_W + 1)'(OUT_W);
    localparam logic [SEL_W:0] LAST_X  = (SEL_W + 1)'(OUT_W - 1);

    state_t state;

    logic             sel_ok;
    logic             at_top;
    logic             at_bottom;
    logic [SEL_W-1:0] step_idx;
    logic             step_edge;

    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
        return OUT_W'(1) << i;
    endfunction

    assign sel_ok    = {1'b0, sel} < OUT_W_X;
    assign at_top    = {1'b0, idx} == LAST_X;
    assign at_bottom = idx == '0;

    always_comb begin
        step_idx  = idx;
        step_edge = 1'b0;
        if (!dir) begin
            if (at_top) begin
                step_edge = 1'b1;
                step_idx  = AUTO_WRAP ? '0 : idx;
            end else begin
                step_idx = idx + 1'b1;
            end
        end else begin
            if (at_bottom) begin
                step_edge = 1'b1;
                step_idx  = AUTO_WRAP ? LAST_X[SEL_W-1:0] : idx;
            end else begin
                step_idx = idx - 1'b1;
            end
        end
    end

    // NOTE: state and every output live in one non-blocking always_ff so all outputs
    // update together on the edge; the async reset branch clears them without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            onehot <= '0;
            idx    <= '0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                state  <= IDLE;
                onehot <= '0;
                idx    <= '0;
                valid  <= 1'b0;
                err    <= 1'b0;
            end else if (load) begin
                if (sel_ok) begin
                    state  <= ACTIVE;
                    onehot <= decode(sel);
                    idx    <= sel;
                    valid  <= 1'b1;
                end else begin
`ifdef ONEHOT_RANGE_CHK_EN
                    err <= 1'b1;
`else
                    state  <= IDLE;
                    onehot <= '0;
                    idx    <= '0;
                    valid  <= 1'b0;
`endif
                end
            end else if (step && state == ACTIVE) begin
                idx    <= step_idx;
                onehot <= decode(step_idx);
                wrap   <= step_edge;
            end
        end
    end

    a_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        valid |-> ($onehot(onehot) && onehot[idx]));

    a_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
        !valid |-> (onehot == '0));

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Directed bench: an 8-wide wrapping instance and a 5-wide saturating instance,
// with hand-computed expectations for load, step, wrap, priority, reset and range.
module tb_onehot_seq_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-wide, AUTO_WRAP=1
    logic       a_clr = 0, a_load = 0, a_step = 0, a_dir = 0;
    logic [2:0] a_sel = 0;
    logic [7:0] a_onehot;
    logic [2:0] a_idx;
    logic       a_valid, a_wrap, a_err;

    // 5-wide, AUTO_WRAP=0
    logic       b_clr = 0, b_load = 0, b_step = 0, b_dir = 0;
    logic [2:0] b_sel = 0;
    logic [4:0] b_onehot;
    logic [2:0] b_idx;
    logic       b_valid, b_wrap, b_err;

    onehot_seq_decoder #(.OUT_W(8), .SEL_W(3), .AUTO_WRAP(1'b1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .sel(a_sel),
        .step(a_step), .dir(a_dir), .onehot(a_onehot), .idx(a_idx),
        .valid(a_valid), .wrap(a_wrap), .err(a_err)
    );

    onehot_seq_decoder #(.OUT_W(5), .SEL_W(3), .AUTO_WRAP(1'b0)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .load(b_load), .sel(b_sel),
        .step(b_step), .dir(b_dir), .onehot(b_onehot), .idx(b_idx),
        .valid(b_valid), .wrap(b_wrap), .err(b_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    endtask

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] oh, input logic [2:0] ix,
                         input logic v, input logic w);
        check({tag, ".onehot"}, 32'(a_onehot), 32'(oh));
        check({tag, ".idx"},    32'(a_idx),    32'(ix));
        check({tag, ".valid"},  32'(a_valid),  32'(v));
        check({tag, ".wrap"},   32'(a_wrap),   32'(w));
    endtask

    task automatic chk_b(input string tag, input logic [4:0] oh, input logic [2:0] ix,
                         input logic v, input logic w, input logic e);
        check({tag, ".onehot"}, 32'(b_onehot), 32'(oh));
        check({tag, ".idx"},    32'(b_idx),    32'(ix));
        check({tag, ".valid"},  32'(b_valid),  32'(v));
        check({tag, ".wrap"},   32'(b_wrap),   32'(w));
        check({tag, ".err"},    32'(b_err),    32'(e));
    endtask

    initial begin
        #1;
        chk_a("rst8", 8'h00, 3'd0, 1'b0, 1'b0);
        check("rst8.err", 32'(a_err), 32'd0);
        chk_b("rst5", 5'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // First load after reset release, then four up-steps to the top.
        a_load = 1; a_sel = 3'd3;
        tick();
        a_load = 0;
        chk_a("load3", 8'h08, 3'd3, 1'b1, 1'b0);

        a_step = 1; a_dir = 0;
        for (int i = 0; i < 3; i++) tick();
        chk_a("step3", 8'h40, 3'd6, 1'b1, 1'b0);
        tick();
        chk_a("step4", 8'h80, 3'd7, 1'b1, 1'b0);

        tick();
        chk_a("wrap_up", 8'h01, 3'd0, 1'b1, 1'b1);
        a_dir = 1;
        tick();
        chk_a("wrap_dn", 8'h80, 3'd7, 1'b1, 1'b1);
        a_step = 0;
        tick();
        chk_a("wrap_pulse_end", 8'h80, 3'd7, 1'b1, 1'b0);

        // load beats step; clr beats load.
        a_load = 1; a_sel = 3'd2; a_step = 1; a_dir = 0;
        tick();
        chk_a("load_vs_step", 8'h04, 3'd2, 1'b1, 1'b0);
        a_clr = 1; a_sel = 3'd5; a_step = 0;
        tick();
        a_clr = 0; a_load = 0;
        chk_a("clr_vs_load", 8'h00, 3'd0, 1'b0, 1'b0);

        a_step = 1;
        tick();
        a_step = 0;
        chk_a("step_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Mid-run async reset: outputs clear with no clock edge in between.
        a_load = 1; a_sel = 3'd5;
        tick();
        a_load = 0;
        chk_a("load5", 8'h20, 3'd5, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_a("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        a_load = 1; a_sel = 3'd1;
        tick();
        a_load = 0;
        chk_a("load_after_rst", 8'h02, 3'd1, 1'b1, 1'b0);

        // Odd width, saturating.
        b_load = 1; b_sel = 3'd4;
        tick();
        b_load = 0;
        chk_b("b_load4", 5'h10, 3'd4, 1'b1, 1'b0, 1'b0);
        b_step = 1; b_dir = 0;
        tick();
        b_step = 0;
        chk_b("b_sat_up", 5'h10, 3'd4, 1'b1, 1'b1, 1'b0);
        tick();
        chk_b("b_sat_end", 5'h10, 3'd4, 1'b1, 1'b0, 1'b0);
        b_step = 1; b_dir = 1;
        tick();
        chk_b("b_dn", 5'h08, 3'd3, 1'b1, 1'b0, 1'b0);
        b_step = 0;
        b_load = 1; b_sel = 3'd0;
        tick();
        b_load = 0; b_step = 1; b_dir = 1;
        tick();
        b_step = 0;
        chk_b("b_sat_dn", 5'h01, 3'd0, 1'b1, 1'b1, 1'b0);

        // Out-of-range load.
        b_load = 1; b_sel = 3'd1;
        tick();
        b_sel = 3'd6;
        tick();
        b_load = 0;
`ifdef ONEHOT_RANGE_CHK_EN
        chk_b("b_range", 5'h02, 3'd1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_b("b_range_sticky", 5'h02, 3'd1, 1'b1, 1'b0, 1'b1);
        b_clr = 1;
        tick();
        b_clr = 0;
        chk_b("b_range_clr", 5'h00, 3'd0, 1'b0, 1'b0, 1'b0);
`else
        chk_b("b_range", 5'h00, 3'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
